// File: rtl/one_wire_pkg.sv
// one_wire_pkg: shared state encoding and constants for the 1-Wire ROM path
package one_wire_pkg;
    typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;
    localparam logic [7:0] CRC_POLY_REFL = 8'h8C;
    localparam int UID_SERIAL_DATA_WIDTH = 56;
    localparam int ROM_ID_WIDTH = 64;
endpackage

// File: rtl/one_wire_crc8_step.sv
// one_wire_crc8_step: single-bit reflected Dallas CRC-8 update, shared with receive-side checkers
module one_wire_crc8_step #(
    parameter logic [7:0] POLY = one_wire_pkg::CRC_POLY_REFL
) (
    input  logic [7:0] crc_in,
    input  logic       bit_in,
    output logic [7:0] crc_out
);
    assign crc_out = (crc_in >> 1) ^ ((crc_in[0] ^ bit_in) ? POLY : 8'h00);
endmodule

// File: rtl/one_wire_rom_tx.sv
// one_wire_rom_tx: serializes a UID LSB-first plus its CRC-8 over valid/ready; ONE_WIRE_ROM_TX_ABORT_EN adds an abort input
module one_wire_rom_tx #(
    parameter int         UID_SERIAL_DATA_WIDTH = one_wire_pkg::UID_SERIAL_DATA_WIDTH,
    parameter logic [7:0] CRC_POLY_REFL         = one_wire_pkg::CRC_POLY_REFL
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [UID_SERIAL_DATA_WIDTH-1:0] uid,
    input  logic                             bit_ready,
`ifdef ONE_WIRE_ROM_TX_ABORT_EN
    input  logic                             abort,
`endif
    output logic                             bit_out,
    output logic                             bit_valid,
    output logic                             busy,
    output logic                             done,
    output logic [7:0]                       crc_data
);
    import one_wire_pkg::state_t;
    import one_wire_pkg::IDLE;
    import one_wire_pkg::DATA;
    import one_wire_pkg::CRC;

    state_t                           state;
    logic [UID_SERIAL_DATA_WIDTH-2:0] shift;
    logic [7:0]                       crc_reg, crc_next;
    logic [6:0]                       cnt;
    logic                             xfer, abort_hit;

    assign xfer = bit_valid && bit_ready;

`ifdef ONE_WIRE_ROM_TX_ABORT_EN
    assign abort_hit = abort && bit_valid;
`else
    assign abort_hit = 1'b0;
`endif

    one_wire_crc8_step #(.POLY(CRC_POLY_REFL)) u_step (
        .crc_in  (crc_reg),
        .bit_in  (bit_out),
        .crc_out (crc_next)
    );

    // Control FSM; shift holds the not-yet-presented UID bits, bit_out the presented one
    always_ff @(posedge clk) begin
        if (!rst_n || abort_hit) begin
            state     <= IDLE;
            shift     <= '0;
            crc_reg   <= '0;
            cnt       <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            crc_data  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    shift     <= uid[UID_SERIAL_DATA_WIDTH-1:1];
                    bit_out   <= uid[0];
                    crc_reg   <= '0;
                    cnt       <= 7'(UID_SERIAL_DATA_WIDTH);
                    crc_data  <= '0;
                    bit_valid <= 1'b1;
                    busy      <= 1'b1;
                    state     <= DATA;
                end
                DATA: if (xfer) begin
                    shift   <= shift >> 1;
                    bit_out <= (cnt == 7'd1) ? crc_next[0] : shift[0];
                    crc_reg <= crc_next;
                    cnt     <= (cnt == 7'd1) ? 7'd8 : cnt - 7'd1;
                    if (cnt == 7'd1) begin
                        crc_data <= crc_next;
                        state    <= CRC;
                    end
                end
                CRC: if (xfer) begin
                    crc_reg <= crc_reg >> 1;
                    bit_out <= (cnt == 7'd1) ? 1'b0 : crc_reg[1];
                    cnt     <= cnt - 7'd1;
                    if (cnt == 7'd1) begin
                        bit_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_one_wire_rom_tx.sv
// tb_one_wire_rom_tx: directed scoreboard bench for one_wire_rom_tx
module tb_one_wire_rom_tx;
    localparam int W = 56;
    localparam logic [W-1:0] KNOWN = 56'h00_0000_01B8_1C02;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] uid = '0;
    logic         bit_ready = 1'b1;
    logic         bit_out, bit_valid, busy, done;
    logic [7:0]   crc_data;
`ifdef ONE_WIRE_ROM_TX_ABORT_EN
    logic         abort = 1'b0;
`endif

    int           errors = 0;
    int           checks = 0;
    logic         exp_q[$];
    logic [7:0]   exp_crc = '0;
    int           xfer_idx = 0;
    logic [7:0]   rx_crc = '0;
    logic         hold = 1'b0;
    logic         hold_bit = 1'b0;
    int           n;

    one_wire_rom_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .uid       (uid),
        .bit_ready (bit_ready),
`ifdef ONE_WIRE_ROM_TX_ABORT_EN
        .abort     (abort),
`endif
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done),
        .crc_data  (crc_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        c = c >> 1;
        return fb ? (c ^ 8'h8C) : c;
    endfunction

    task automatic do_start(input logic [W-1:0] u);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            exp_q.push_back(u[i]);
            c = crc_step(c, u[i]);
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(c[i]);
        exp_crc = c;
        uid = u;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input bit bp, output int cyc);
        cyc = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1 cyc++;
            if (bp) bit_ready = ($urandom_range(0, 99) < 40);
            if (done) break;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_bit_out"}, bit_out, 0);
        chk({tag, "_bit_valid"}, bit_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_crc_data"}, crc_data, 0);
    endtask

    // Monitor: pops expected bits on transfers, checks hold stability, done placement and receiver residue
    always @(negedge clk) begin
        if (!rst_n) begin
            xfer_idx = 0;
            rx_crc = '0;
            hold = 1'b0;
        end else begin
            if (done) begin
                chk("done_after_64", xfer_idx, 64);
                chk("rx_residue", rx_crc, 0);
            end
            if (hold && bit_valid) chk("hold_stable", bit_out, hold_bit);
            if (bit_valid && xfer_idx == 56) chk("crc_data_at_crc", crc_data, exp_crc);
            if (bit_valid && bit_ready) begin
                chk("q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("bit", bit_out, exp_q.pop_front());
                rx_crc = crc_step(rx_crc, bit_out);
                xfer_idx++;
            end
            hold = bit_valid && !bit_ready;
            hold_bit = bit_out;
            if (!bit_valid) begin
                xfer_idx = 0;
                rx_crc = '0;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 chk_reset_outs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        // known vector with continuous ready
        #1 do_start(KNOWN);
        chk("start_valid", bit_valid, 1);
        chk("start_busy", busy, 1);
        chk("start_bit0", bit_out, KNOWN[0]);
        chk("start_crc_clear", crc_data, 0);
        wait_done(1'b0, n);
        chk("known_latency", n, 64);
        chk("known_crc", crc_data, 8'hA2);
        chk("known_busy_low", busy, 0);
        chk("known_q_empty", exp_q.size(), 0);
        // all-zero UID started in the done cycle
        do_start('0);
        chk("b2b_valid", bit_valid, 1);
        chk("done_one_cycle", done, 0);
        wait_done(1'b0, n);
        chk("zero_latency", n, 64);
        chk("zero_crc", crc_data, 8'h00);
        @(posedge clk);
        #1 chk("zero_done_once", done, 0);
        // backpressure
        do_start(KNOWN);
        wait_done(1'b1, n);
        bit_ready = 1'b1;
        chk("bp_crc", crc_data, 8'hA2);
        chk("bp_q_empty", exp_q.size(), 0);
        @(posedge clk);
        // start while busy is ignored
        #1 do_start(KNOWN);
        repeat (9) @(posedge clk);
        #1 start = 1'b1;
        uid = '1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(1'b0, n);
        chk("busy_start_latency", n, 54);
        chk("busy_start_crc", crc_data, 8'hA2);
        chk("busy_start_q_empty", exp_q.size(), 0);
        @(posedge clk);
        // mid-operation reset
        #1 do_start(KNOWN);
        repeat (29) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 chk_reset_outs("midrst");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("midrst_idle", bit_valid, 0);
        do_start(W'({$urandom, $urandom}));
        wait_done(1'b0, n);
        chk("fresh_latency", n, 64);
        chk("fresh_crc", crc_data, exp_crc);
`ifdef ONE_WIRE_ROM_TX_ABORT_EN
        @(posedge clk);
        #1 do_start(KNOWN);
        repeat (59) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        exp_q.delete();
        chk_reset_outs("abort");
        @(posedge clk);
        #1 chk("abort_no_done", done, 0);
        do_start(KNOWN);
        wait_done(1'b0, n);
        chk("post_abort_latency", n, 64);
        chk("post_abort_crc", crc_data, 8'hA2);
`endif
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
